// File: rtl/cn_msg_expander_if.sv
// Handshake bundle for the check-to-variable message expander.
// Record input (in_*) and per-edge message output (out_*).
interface cn_msg_expander_if #(
    parameter int DEG   = 16,
    parameter int MAG_W = 5,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] in_min1;
    logic [MAG_W-1:0] in_min2;
    logic [IDX_W-1:0] in_min1_idx;
    logic [DEG-1:0]   in_signs;
    logic             out_valid;
    logic             out_ready;
    logic [MAG_W:0]   out_msg;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_min1, in_min2, in_min1_idx, in_signs, out_ready,
        input  in_ready, out_valid, out_msg, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_min1, in_min2, in_min1_idx, in_signs, out_ready,
        output in_ready, out_valid, out_msg, out_idx, out_last
    );
endinterface

// File: rtl/cn_msg_expander.sv
// Expands one compressed min-sum check-node record into DEG offset-min-sum
// check-to-variable messages, one sign-magnitude beat per cycle.
module cn_msg_expander #(
    parameter int DEG    = 16,
    parameter int MAG_W  = 5,
    parameter int IDX_W  = 4,
    parameter int OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    cn_msg_expander_if.slave bus
);

    localparam logic [0:0]       STATE_IDLE = 1'b0;
    localparam logic [0:0]       STATE_EMIT = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEG - 1);
    localparam logic [MAG_W-1:0] OFF        = MAG_W'(OFFSET);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0] min1_q, min1_d;
    logic [MAG_W-1:0] min2_q, min2_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DEG-1:0]   signs_q, signs_d;
    logic             par_q, par_d;

    logic             out_valid;
    logic             at_last;
    logic             consume;
    logic             in_ready;
    logic             accept;
    logic [MAG_W-1:0] raw;
    logic [MAG_W-1:0] mag;
    logic             sgn;

    // NOTE: every _d gets its _q as a default first so no path through the
    // block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        out_valid = (state_q == STATE_EMIT);
        at_last   = (cnt_q == LAST_IDX);
        consume   = out_valid && bus.out_ready;
        // Accepting alongside the final consume lets bursts run back to back.
        in_ready  = (state_q == STATE_IDLE) || (consume && at_last);
        accept    = bus.in_valid && in_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        signs_d = signs_q;
        par_d   = par_q;

        if (consume) begin
            if (at_last) begin
                cnt_d   = '0;
                state_d = STATE_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (accept) begin
            state_d = STATE_EMIT;
            cnt_d   = '0;
            min1_d  = bus.in_min1;
            min2_d  = bus.in_min2;
            idx_d   = bus.in_min1_idx;
            signs_d = bus.in_signs;
            par_d   = ^bus.in_signs;
        end
    end

    // The edge that supplied min1 must not see its own value, so it gets min2.
    always_comb begin
        raw = (cnt_q == idx_q) ? min2_q : min1_q;
        mag = (raw > OFF) ? (raw - OFF) : '0;
        sgn = (mag != '0) && (par_q ^ signs_q[cnt_q]);

        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_idx   = cnt_q;
        bus.out_last  = out_valid && at_last;
        bus.out_msg   = out_valid ? {sgn, mag} : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_IDLE;
            cnt_q   <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            idx_q   <= '0;
            signs_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx_q   <= idx_d;
            signs_q <= signs_d;
            par_q   <= par_d;
        end
    end

endmodule

// File: tb/tb_cn_msg_expander.sv
// Self-checking bench for cn_msg_expander: directed scenarios plus random
// traffic against a queue-based reference model of the expected beats.
module tb_cn_msg_expander;

    localparam int DEG    = 16;
    localparam int MAG_W  = 5;
    localparam int IDX_W  = 4;
    localparam int OFFSET = 1;

    typedef struct packed {
        logic [MAG_W-1:0] min1;
        logic [MAG_W-1:0] min2;
        logic [IDX_W-1:0] idx;
        logic [DEG-1:0]   signs;
    } rec_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [MAG_W:0]   msg;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cn_msg_expander_if #(.DEG(DEG), .MAG_W(MAG_W), .IDX_W(IDX_W)) bus ();

    cn_msg_expander #(.DEG(DEG), .MAG_W(MAG_W), .IDX_W(IDX_W), .OFFSET(OFFSET)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected message for edge i, straight from the offset-min-sum rules.
    function automatic logic [MAG_W:0] ref_msg(input rec_t r, input int i);
        int par = $countones(r.signs) % 2;
        int raw = (i == int'(r.idx)) ? int'(r.min2) : int'(r.min1);
        int mag = (raw > OFFSET) ? raw - OFFSET : 0;
        int sgn = (mag == 0) ? 0 : (par ^ int'(r.signs[i]));
        return {sgn[0], mag[MAG_W-1:0]};
    endfunction

    task automatic push_rec(input rec_t r);
        beat_t b;
        for (int i = 0; i < DEG; i++) begin
            b.idx  = IDX_W'(i);
            b.msg  = ref_msg(r, i);
            b.last = (i == DEG - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock: drive inputs at negedge, check outputs, advance the model.
    task automatic step(input logic v, input rec_t r, input logic ordy);
        beat_t       f;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] g;
        rec_t        drv;
        @(negedge clk);
        g   = $urandom;
        drv = v ? r : rec_t'(g[29:0]);
        bus.in_valid    = v;
        bus.in_min1     = drv.min1;
        bus.in_min2     = drv.min2;
        bus.in_min1_idx = drv.idx;
        bus.in_signs    = drv.signs;
        bus.out_ready   = ordy;
        #1;
        exp_valid = (exp_q.size() > 0);
        exp_ready = !exp_valid || (ordy && exp_q[0].last);
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (exp_valid) begin
            f = exp_q[0];
            check("out_idx", 32'(bus.out_idx), 32'(f.idx));
            check("out_msg", 32'(bus.out_msg), 32'(f.msg));
            check("out_last", 32'(bus.out_last), 32'(f.last));
            if (ordy) void'(exp_q.pop_front());
        end
        if (v && exp_ready) push_rec(r);
    endtask

    // Accept r, then consume its beats, stalling once before each beat whose
    // stall bit is set; optionally present nxt during the final beat.
    task automatic send(input rec_t r, input logic [DEG-1:0] stall,
                        input logic chain, input rec_t nxt);
        step(1'b1, r, 1'b1);
        for (int b = 0; b < DEG; b++) begin
            if (stall[b]) step(1'b0, r, 1'b0);
            step(chain && (b == DEG - 1), nxt, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idx"}, 32'(bus.out_idx), 32'd0);
        check({tag, "_msg"}, 32'(bus.out_msg), 32'd0);
        check({tag, "_last"}, 32'(bus.out_last), 32'd0);
    endtask

    rec_t t1, t3, t4, t5, rr;
    logic [31:0] g0, g1;

    initial begin
        t1 = '{min1: 5'd2, min2: 5'd3, idx: 4'd1,  signs: 16'h0005};
        t3 = '{min1: 5'd4, min2: 5'd7, idx: 4'd15, signs: 16'h0000};
        t4 = '{min1: 5'd0, min2: 5'd1, idx: 4'd0,  signs: 16'h0002};
        t5 = '{min1: 5'd5, min2: 5'd9, idx: 4'd8,  signs: 16'h0001};

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_min1     = '0;
        bus.in_min2     = '0;
        bus.in_min1_idx = '0;
        bus.in_signs    = '0;
        bus.out_ready   = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(t1, 16'h0000, 1'b0, t1);
        send(t1, 16'h8061, 1'b0, t1);
        send(t1, 16'h0000, 1'b1, t3);
        for (int b = 0; b < DEG; b++) step(1'b0, t3, 1'b1);
        send(t4, 16'h0000, 1'b0, t4);
        send(t5, 16'h0000, 1'b0, t5);

        // Reset in the middle of a burst, after beat 7 is consumed.
        step(1'b1, t1, 1'b1);
        for (int b = 0; b < 8; b++) step(1'b0, t1, 1'b1);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step(1'b0, t1, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            g0    = $urandom;
            g1    = $urandom;
            rr    = rec_t'(g0[29:0]);
            step(g1[1:0] == 2'd0, rr, g1[4:2] != 3'd0);
        end

        for (int c = 0; c < 100 && exp_q.size() > 0; c++) step(1'b0, t1, 1'b1);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
